// File: rtl/microcode_sequencer.sv
// Microcode sequencer: steps a micro-PC through an external combinational
// micro-ROM, one micro-op per cycle. It supports jumps, conditional branches,
// a micro-call stack and bus operations that wait on a completion handshake.
//
// Ports:
//   clk, reset               clock; asynchronous active-high reset
//   start, entry_addr        decoded instruction ready and its micro-ROM entry
//   flush                    abort the running sequence, return to idle
//   uaddr / uop              micro-ROM address (the upc register) and its data
//   cond                     condition flags, selected by the uop csel field
//   uop_valid, uop_payload   issue strobe and low payload bits for the datapath
//   bus_command(_done)       registered bus request (1 rd, 2 wr) and completion
//   busy                     sequencer not idle
//   instruction_nearly_done  an END uop is issuing this cycle
//   instruction_done         one-cycle pulse on the cycle after END or a stack abort
//   stack_error              sticky call-overflow / return-underflow flag
module microcode_sequencer #(
  parameter int UADDR_W     = 9,
  parameter int UOP_W       = 24,
  parameter int NUM_COND    = 8,
  parameter int STACK_DEPTH = 4,
  localparam int CSEL_W     = (NUM_COND > 1) ? $clog2(NUM_COND) : 1,
  localparam int PAY_W      = UOP_W - 6 - UADDR_W - CSEL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [UADDR_W-1:0] entry_addr,
  input  logic               flush,
  output logic [UADDR_W-1:0] uaddr,
  input  logic [UOP_W-1:0]   uop,
  input  logic [NUM_COND-1:0] cond,
  output logic               uop_valid,
  output logic [PAY_W-1:0]   uop_payload,
  output logic [1:0]         bus_command,
  input  logic               bus_command_done,
  output logic               busy,
  output logic               instruction_nearly_done,
  output logic               instruction_done,
  output logic               stack_error
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  localparam logic [2:0] SEQ_NEXT  = 3'd0;
  localparam logic [2:0] SEQ_JUMP  = 3'd1;
  localparam logic [2:0] SEQ_JCOND = 3'd2;
  localparam logic [2:0] SEQ_CALL  = 3'd3;
  localparam logic [2:0] SEQ_RET   = 3'd4;
  localparam logic [2:0] SEQ_BUS   = 3'd5;
  localparam logic [2:0] SEQ_END   = 3'd6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    BUS_WAIT = 2'd2
  } state_t;

  state_t             state;
  logic [UADDR_W-1:0] upc;
  logic [UADDR_W-1:0] upc_inc;
  logic [SP_W-1:0]    sp;

  // Storage is rounded up to a power of two so every index value is in range.
  logic [UADDR_W-1:0] stack_mem [2**IDX_W];
  logic [IDX_W-1:0]   push_idx;
  logic [IDX_W-1:0]   pop_idx;

  // Micro-op fields, MSB first: seq, target, csel, inv, buscmd, payload.
  logic [2:0]         f_seq;
  logic [UADDR_W-1:0] f_target;
  logic [CSEL_W-1:0]  f_csel;
  logic               f_inv;
  logic [1:0]         f_buscmd;

  logic exec;
  logic cond_taken;
  logic stack_fault;
  logic push_en;

  assign f_seq    = uop[UOP_W-1 -: 3];
  assign f_target = uop[UOP_W-4 -: UADDR_W];
  assign f_csel   = uop[UOP_W-4-UADDR_W -: CSEL_W];
  assign f_inv    = uop[UOP_W-4-UADDR_W-CSEL_W];
  assign f_buscmd = uop[UOP_W-5-UADDR_W-CSEL_W -: 2];

  assign exec       = (state == EXEC);
  assign upc_inc    = upc + 1'b1;  // wraps modulo 2^UADDR_W
  assign cond_taken = cond[f_csel] ^ f_inv;
  assign push_idx   = IDX_W'(sp);
  assign pop_idx    = IDX_W'(sp - 1'b1);

  assign stack_fault = exec && (((f_seq == SEQ_CALL) && (sp == SP_FULL)) ||
                                ((f_seq == SEQ_RET)  && (sp == '0)));
  assign push_en     = exec && (f_seq == SEQ_CALL) && !stack_fault && !flush;

  assign uaddr                   = upc;
  assign uop_valid               = exec;
  assign uop_payload             = exec ? uop[PAY_W-1:0] : '0;
  assign busy                    = (state != IDLE);
  assign instruction_nearly_done = exec && (f_seq == SEQ_END);

  // Stack contents need no reset: sp alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[push_idx] <= upc_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      upc              <= '0;
      sp               <= '0;
      bus_command      <= 2'd0;
      instruction_done <= 1'b0;
      stack_error      <= 1'b0;
    end else begin
      instruction_done <= 1'b0;
      if (flush) begin
        // The BCU tolerates a command dropped mid-transfer; no done pulse.
        state       <= IDLE;
        bus_command <= 2'd0;
        sp          <= '0;
      end else if (stack_fault) begin
        stack_error      <= 1'b1;
        state            <= IDLE;
        instruction_done <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              upc   <= entry_addr;
              sp    <= '0;
              state <= EXEC;
            end
          end
          EXEC: begin
            case (f_seq)
              SEQ_JUMP:  upc <= f_target;
              SEQ_JCOND: upc <= cond_taken ? f_target : upc_inc;
              SEQ_CALL: begin
                upc <= f_target;
                sp  <= sp + 1'b1;
              end
              SEQ_RET: begin
                upc <= stack_mem[pop_idx];
                sp  <= sp - 1'b1;
              end
              SEQ_BUS: begin
                bus_command <= f_buscmd;
                upc         <= upc_inc;
                state       <= BUS_WAIT;
              end
              SEQ_END: begin
                instruction_done <= 1'b1;
                // A start during END chains the next instruction with no bubble.
                if (start) begin
                  upc <= entry_addr;
                  sp  <= '0;
                end else begin
                  state <= IDLE;
                end
              end
              default:   upc <= upc_inc;  // NEXT and the reserved code
            endcase
          end
          BUS_WAIT: begin
            if (bus_command_done) begin
              bus_command <= 2'd0;
              state       <= EXEC;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
module tb_microcode_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  entry_addr;
  logic        flush;
  logic [8:0]  uaddr;
  logic [23:0] uop;
  logic [7:0]  cond;
  logic        uop_valid;
  logic [5:0]  uop_payload;
  logic [1:0]  bus_command;
  logic        bus_command_done;
  logic        busy;
  logic        instruction_nearly_done;
  logic        instruction_done;
  logic        stack_error;

  int vectors = 0;
  int miscompares = 0;

  logic [23:0] rom [512];
  assign uop = rom[uaddr];

  always #5 clk = ~clk;

  microcode_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .entry_addr(entry_addr),
    .flush(flush), .uaddr(uaddr), .uop(uop), .cond(cond),
    .uop_valid(uop_valid), .uop_payload(uop_payload),
    .bus_command(bus_command), .bus_command_done(bus_command_done),
    .busy(busy), .instruction_nearly_done(instruction_nearly_done),
    .instruction_done(instruction_done), .stack_error(stack_error)
  );

  // Reference model: mode 0 idle, 1 issuing, 2 waiting on the bus.
  int         m_mode;
  logic [8:0] m_pc;
  logic [1:0] m_cmd;
  logic       m_done;
  logic       m_err;
  logic [8:0] m_stk [$];

  function automatic logic [23:0] mk(input int seq, input int tgt, input int csel,
                                     input int inv, input int bcmd, input int pay);
    logic [23:0] w;
    w = 24'((seq << 21) | (tgt << 12) | (csel << 9) | (inv << 8) | (bcmd << 6) | pay);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = '0; m_cmd = '0; m_done = 1'b0; m_err = 1'b0;
    m_stk.delete();
  endtask

  task automatic check_outputs();
    logic [23:0] u;
    int seq;
    u   = rom[m_pc];
    seq = int'(u >> 21);
    chk("uaddr", 32'(uaddr), 32'(m_pc));
    chk("uop_valid", 32'(uop_valid), 32'(m_mode == 1));
    chk("payload", 32'(uop_payload), (m_mode == 1) ? 32'(u & 24'h3F) : 32'd0);
    chk("nearly_done", 32'(instruction_nearly_done), 32'((m_mode == 1) && (seq == 6)));
    chk("busy", 32'(busy), 32'(m_mode != 0));
    chk("bus_command", 32'(bus_command), 32'(m_cmd));
    chk("instr_done", 32'(instruction_done), 32'(m_done));
    chk("stack_error", 32'(stack_error), 32'(m_err));
  endtask

  task automatic model_step();
    logic [23:0] u;
    int seq, tgt, csel, inv;
    logic [8:0] nxt;
    u    = rom[m_pc];
    seq  = int'(u >> 21);
    tgt  = int'((u >> 12) & 24'h1FF);
    csel = int'((u >> 9) & 24'h7);
    inv  = int'((u >> 8) & 24'h1);
    nxt  = m_pc + 9'd1;
    m_done = 1'b0;
    if (flush) begin
      m_mode = 0; m_cmd = '0; m_stk.delete();
    end else if (m_mode == 0) begin
      if (start) begin m_pc = entry_addr; m_stk.delete(); m_mode = 1; end
    end else if (m_mode == 2) begin
      if (bus_command_done) begin m_cmd = '0; m_mode = 1; end
    end else begin
      case (seq)
        1: m_pc = 9'(tgt);
        2: m_pc = ((int'(cond[csel]) ^ inv) != 0) ? 9'(tgt) : nxt;
        3: if (m_stk.size() == 4) begin m_err = 1; m_mode = 0; m_done = 1; end
           else begin m_stk.push_back(nxt); m_pc = 9'(tgt); end
        4: if (m_stk.size() == 0) begin m_err = 1; m_mode = 0; m_done = 1; end
           else m_pc = m_stk.pop_back();
        5: begin m_cmd = 2'(u >> 6); m_pc = nxt; m_mode = 2; end
        6: begin
             m_done = 1;
             if (start) begin m_pc = entry_addr; m_stk.delete(); end
             else m_mode = 0;
           end
        default: m_pc = nxt;
      endcase
    end
  endtask

  // One clock: check at the falling edge, advance the model, then release
  // the single-cycle inputs just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0; bus_command_done = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = '0;
    rom[9'h010] = mk(0, 0, 0, 0, 0, 6'h11);
    rom[9'h011] = mk(0, 0, 0, 0, 0, 6'h22);
    rom[9'h012] = mk(6, 0, 0, 0, 0, 6'h33);
    rom[9'h030] = mk(2, 9'h1A0, 3, 0, 0, 1);
    rom[9'h031] = mk(6, 0, 0, 0, 0, 0);
    rom[9'h038] = mk(2, 9'h1A0, 3, 1, 0, 2);
    rom[9'h039] = mk(6, 0, 0, 0, 0, 0);
    rom[9'h1A0] = mk(6, 0, 0, 0, 0, 3);
    rom[9'h020] = mk(3, 9'h100, 0, 0, 0, 4);
    rom[9'h021] = mk(6, 0, 0, 0, 0, 5);
    rom[9'h100] = mk(4, 0, 0, 0, 0, 6);
    rom[9'h050] = mk(5, 0, 0, 0, 1, 7);
    rom[9'h051] = mk(6, 0, 0, 0, 0, 8);
    rom[9'h040] = mk(6, 0, 0, 0, 0, 9);
    for (int i = 0; i < 5; i++) rom[9'h080 + i] = mk(3, 9'h081 + i, 0, 0, 0, i);
    rom[9'h1FF] = mk(0, 0, 0, 0, 0, 6'h3F);
    rom[9'h000] = mk(6, 0, 0, 0, 0, 6'h01);
    for (int i = 9'h1C0; i < 9'h1FF; i++)
      rom[i] = mk($urandom_range(7), 9'h1C0 + $urandom_range(63), $urandom_range(7),
                  $urandom_range(1), $urandom_range(2), $urandom_range(63));

    reset = 1'b1; start = 1'b0; entry_addr = '0; flush = 1'b0;
    cond = '0; bus_command_done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_uaddr", 32'(uaddr), 0);
    chk("rst_valid", 32'(uop_valid), 0);
    reset = 1'b0;

    // Linear NEXT, NEXT, END from 0x010.
    start = 1; entry_addr = 9'h010; cycle();
    chk("lin_a0", 32'(uaddr), 32'h010); cycle();
    chk("lin_a1", 32'(uaddr), 32'h011); cycle();
    chk("lin_a2", 32'(uaddr), 32'h012);
    chk("lin_nd", 32'(instruction_nearly_done), 1); cycle();
    chk("lin_done", 32'(instruction_done), 1);
    chk("lin_idle", 32'(busy), 0);

    // Conditional branch, taken then inverted (not taken).
    cond = 8'h08; start = 1; entry_addr = 9'h030; cycle(); cycle();
    chk("jc_taken", 32'(uaddr), 32'h1A0); cycle(); cycle();
    start = 1; entry_addr = 9'h038; cycle(); cycle();
    chk("jc_inv", 32'(uaddr), 32'h039); cycle(); cycle();

    // Call and return.
    start = 1; entry_addr = 9'h020; cycle(); cycle();
    chk("call_tgt", 32'(uaddr), 32'h100); cycle();
    chk("ret_addr", 32'(uaddr), 32'h021); cycle(); cycle();

    // Bus read held for three cycles, then a done pulse while idle.
    start = 1; entry_addr = 9'h050; cycle(); cycle();
    for (int i = 0; i < 3; i++) begin
      chk("bus_held", 32'(bus_command), 1);
      chk("bus_novalid", 32'(uop_valid), 0);
      if (i == 2) bus_command_done = 1;
      cycle();
    end
    chk("bus_clear", 32'(bus_command), 0);
    chk("bus_resume", 32'(uaddr), 32'h051); cycle(); cycle();
    bus_command_done = 1; cycle();
    chk("bus_idle_ign", 32'(busy), 0);

    // Back-to-back start during END.
    start = 1; entry_addr = 9'h010; cycle(); cycle(); cycle();
    start = 1; entry_addr = 9'h040; cycle();
    chk("b2b_addr", 32'(uaddr), 32'h040);
    chk("b2b_valid", 32'(uop_valid), 1); cycle(); cycle();

    // Flush while waiting on the bus.
    start = 1; entry_addr = 9'h050; cycle(); cycle();
    flush = 1; cycle();
    chk("flush_idle", 32'(busy), 0);
    chk("flush_cmd", 32'(bus_command), 0); cycle();
    chk("flush_nodone", 32'(instruction_done), 0);

    // upc wraps from 0x1FF to 0x000.
    start = 1; entry_addr = 9'h1FF; cycle(); cycle();
    chk("wrap", 32'(uaddr), 0); cycle(); cycle();

    // Fifth nested call overflows the four-entry stack.
    start = 1; entry_addr = 9'h080; cycle();
    repeat (4) cycle();
    chk("ovf_at", 32'(uaddr), 32'h084); cycle();
    chk("ovf_err", 32'(stack_error), 1);
    chk("ovf_idle", 32'(busy), 0);
    chk("ovf_done", 32'(instruction_done), 1); cycle();

    // Asynchronous reset while a bus command is outstanding.
    start = 1; entry_addr = 9'h050; cycle(); cycle();
    chk("pre_rst_cmd", 32'(bus_command), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_cmd", 32'(bus_command), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_valid", 32'(uop_valid), 0);
    chk("arst_err", 32'(stack_error), 0);
    chk("arst_uaddr", 32'(uaddr), 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    chk("arst_rel", 32'(busy), 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      start            = ($urandom_range(3) == 0);
      entry_addr       = 9'(32'h1C0 + $urandom_range(63));
      cond             = 8'($urandom);
      flush            = ($urandom_range(31) == 0);
      bus_command_done = ($urandom_range(2) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
